// File: rtl/apb_cmd_initiator.sv
// APB initiator: turns single valid/ready commands into one APB transfer each and
// returns read data / error status on a valid/ready response channel, with bounded wait.
module apb_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hBADD_C0DE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          timeout_hit_s;

    // pready has priority, so a timeout only fires on a cycle where the responder is still stalling
    assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == CNT_LAST) && !pready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) state_d = S_SETUP;
                else             state_d = S_IDLE;
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_i || timeout_hit_s) state_d = S_RESP;
                else                           state_d = S_ACCESS;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
                else             state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values; everything except cmd_ready is registered from these
    always_comb begin
        psel_d        = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d     = (state_d == S_ACCESS);
        rsp_valid_d   = (state_d == S_RESP);
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                end else begin
                    pwrite_d = pwrite_q;
                end
            end
            S_SETUP: cnt_d = {CW{1'b0}};
            S_ACCESS: begin
                if (pready_i) begin
                    rsp_rdata_d   = pwrite_q ? 32'h0000_0000 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit_s) begin
                    rsp_rdata_d   = pwrite_q ? 32'h0000_0000 : ERR_DATA;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RESP:  cnt_d = cnt_q;
            default: cnt_d = {CW{1'b0}};
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= {CW{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'h0000_0000;
            pwdata_q      <= 32'h0000_0000;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0000_0000;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Directed bench for apb_cmd_initiator with a small wait-state-programmable APB responder.
module tb_apb_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    logic [3:0]  wait_cfg;
    logic        hang, err_cfg;
    logic [31:0] prdata_cfg;
    logic [3:0]  acc_cnt;

    int n_assert;
    int n_fail;

    apb_cmd_initiator #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hBADD_C0DE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    // Responder: raises pready after wait_cfg stalled ACCESS cycles unless hung
    always @(posedge clk) begin
        if (!penable) acc_cnt <= 4'd0;
        else if (!pready) acc_cnt <= acc_cnt + 4'd1;
    end
    assign pready  = psel && penable && !hang && (acc_cnt == wait_cfg);
    assign pslverr = pready && err_cfg;
    assign prdata  = prdata_cfg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0; wait_cfg = 4'd0; hang = 1'b0; err_cfg = 1'b0; prdata_cfg = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: zero-wait write
        issue(1'b1, 32'h40, 32'h5A);
        @(negedge clk); cmd_valid = 1'b0;
        chk("t1_setup_psel", {30'd0, psel, penable}, 32'd2);
        chk("t1_setup_paddr", paddr, 32'h40);
        chk("t1_setup_pwdata", pwdata, 32'h5A);
        chk("t1_setup_pwrite", {31'd0, pwrite}, 32'd1);
        chk("t1_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("t1_access", {29'd0, psel, penable, rsp_valid}, 32'd6);
        @(negedge clk);
        chk("t1_resp", {29'd0, psel, penable, rsp_valid}, 32'd1);
        chk("t1_rsp_status", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("t1_rsp_rdata", rsp_rdata, 32'd0);
        ack_rsp();
        chk("t1_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);

        // 2: read with two wait states
        wait_cfg = 4'd2; prdata_cfg = 32'h9;
        issue(1'b0, 32'h48, 32'hFFFF);
        @(negedge clk); cmd_valid = 1'b0;
        chk("t2_setup", {30'd0, psel, penable}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2_access%0d", i), {29'd0, psel, penable, rsp_valid}, 32'd6);
        end
        @(negedge clk);
        chk("t2_resp", {29'd0, psel, penable, rsp_valid}, 32'd1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h9);
        chk("t2_rsp_status", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        ack_rsp();

        // 3: slave error on unmapped read
        wait_cfg = 4'd0; err_cfg = 1'b1; prdata_cfg = 32'hBADD_C0DE;
        issue(1'b0, 32'h7C, 32'd0);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_rsp_status", {30'd0, rsp_err, rsp_timeout}, 32'd2);
        chk("t3_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
        ack_rsp();
        err_cfg = 1'b0;

        // 4: hung responder, timeout after 4 ACCESS cycles
        hang = 1'b1; prdata_cfg = 32'h1111_1111;
        issue(1'b0, 32'h60, 32'd0);
        @(negedge clk); cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t4_access%0d", i), {29'd0, psel, penable, rsp_valid}, 32'd6);
        end
        @(negedge clk);
        chk("t4_resp", {29'd0, psel, penable, rsp_valid}, 32'd1);
        chk("t4_rsp_status", {30'd0, rsp_err, rsp_timeout}, 32'd3);
        chk("t4_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
        ack_rsp();
        hang = 1'b0;

        // 5: backpressured response with a second command waiting
        issue(1'b1, 32'h48, 32'h1234);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        issue(1'b0, 32'h50, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_hold%0d", i), {28'd0, rsp_valid, cmd_ready, psel, rsp_timeout}, 32'd8);
            chk($sformatf("t5_rdata%0d", i), rsp_rdata, 32'd0);
            chk($sformatf("t5_paddr%0d", i), paddr, 32'h48);
            @(negedge clk);
        end
        ack_rsp();
        chk("t5_after_ack", {29'd0, rsp_valid, cmd_ready, psel}, 32'd2);
        @(negedge clk); cmd_valid = 1'b0;
        chk("t5_second_setup", {30'd0, psel, penable}, 32'd2);
        chk("t5_second_paddr", paddr, 32'h50);
        chk("t5_second_pwrite", {31'd0, pwrite}, 32'd0);
        prdata_cfg = 32'hCAFE;
        @(negedge clk);
        @(negedge clk);
        chk("t5_second_rdata", rsp_rdata, 32'hCAFE);
        ack_rsp();

        // 6: reset during ACCESS
        hang = 1'b1;
        issue(1'b0, 32'h70, 32'd0);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_access", {30'd0, psel, penable}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {29'd0, psel, penable, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; hang = 1'b0;
        @(negedge clk);
        chk("t6_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        issue(1'b1, 32'h44, 32'h77);
        @(negedge clk); cmd_valid = 1'b0;
        chk("t6_new_paddr", paddr, 32'h44);
        @(negedge clk);
        @(negedge clk);
        chk("t6_new_resp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd4);
        ack_rsp();
        chk("t6_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
